car_motion_ctrl: RTL and testbench

- Sequential counterpart to the combinational direction decoder in the elevator controller.
- Latches hall/car button presses into the 8-bit request vector `signal` and holds the car position `current` (binary 1..8); the decoder consumes both.
- Consumes the decoder's direction pair (`up` = F1, `down` = F0) and moves the car one floor per `FLOOR_TICKS` cycles.
- At each requested floor it opens the door for `DOOR_TICKS` cycles and clears that request.

---
 rtl/elevator_pkg.sv | 37 +++
 rtl/car_motion_ctrl_tick_timer.sv | 38 +++
 rtl/car_motion_ctrl.sv | 155 +++++++++++++++
 tb/tb_car_motion_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Types and constants shared by the elevator car controller.
//                State encoding for the car FSM, floor range constants and
//                a helper that turns a binary floor number into a one-hot
//                request mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = 4;

    localparam logic [FLOOR_W-1:0] FLOOR_MIN = 4'd1;
    localparam logic [FLOOR_W-1:0] FLOOR_MAX = 4'd8;

    // One-hot mask for a floor (bit i = floor i+1). Out-of-range floors
    // yield an all-zero mask so they can never set or clear a request.
    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] floor);
        logic [NUM_FLOORS-1:0] mask;
        mask = '0;
        if ((floor >= FLOOR_MIN) && (floor <= FLOOR_MAX)) begin
            mask = NUM_FLOORS'(1) << (floor - FLOOR_MIN);
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/car_motion_ctrl_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_timer
//  Description : Loadable down-counter. Counts down once per cycle and parks
//                at zero; a load overrides the count.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset (count = 0)
//                load       - load load_value this cycle
//                load_value - value to load
//                zero       - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/car_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : car_motion_ctrl
//  Description : Sequential side of the elevator controller. Latches button
//                presses into the pending-request vector, holds the car
//                position and moves the car one floor per FLOOR_TICKS cycles
//                as commanded by the direction decoder. Opens the door for
//                DOOR_TICKS cycles at each requested floor.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                btn[7:0]  - request buttons, bit i = floor i+1
//                up        - move-up command from the decoder
//                down      - move-down command from the decoder
//                current   - car floor, binary 1..8
//                signal    - latched pending requests, bit i = floor i+1
//                door_open - door is open
//                moving    - car is travelling between floors
//  Revision    : 1.0 - initial release
// ============================================================================
module car_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic                  up,
    input  logic                  down,
    output logic [FLOOR_W-1:0]    current,
    output logic [NUM_FLOORS-1:0] signal,
    output logic                  door_open,
    output logic                  moving
);

    localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TIMER_W-1:0] FLOOR_LOAD = TIMER_W'(FLOOR_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD  = TIMER_W'(DOOR_TICKS - 1);

    state_t                  state;
    state_t                  state_next;
    logic [FLOOR_W-1:0]      current_next;
    logic [NUM_FLOORS-1:0]   signal_next;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [FLOOR_W-1:0]      arrive_floor;
    logic                    floor_legal;
    logic                    timer_load;
    logic [TIMER_W-1:0]      timer_value;
    logic                    timer_zero;

    tick_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    assign floor_legal  = (current >= FLOOR_MIN) && (current <= FLOOR_MAX);
    assign arrive_floor = (state == MOVE_DOWN) ? (current - FLOOR_W'(1))
                                               : (current + FLOOR_W'(1));

    always_comb begin
        state_next   = state;
        current_next = current;
        clear_mask   = '0;
        timer_load   = 1'b0;
        timer_value  = '0;

        case (state)
            IDLE: begin
                // Serving the current floor takes priority over travel.
                if ((signal & floor_bit(current)) != '0) begin
                    state_next  = DOOR;
                    clear_mask  = floor_bit(current);
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (up && !down && (current < FLOOR_MAX)) begin
                    state_next  = MOVE_UP;
                    timer_load  = 1'b1;
                    timer_value = FLOOR_LOAD;
                end else if (down && !up && (current > FLOOR_MIN)) begin
                    state_next  = MOVE_DOWN;
                    timer_load  = 1'b1;
                    timer_value = FLOOR_LOAD;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (timer_zero) begin
                    current_next = arrive_floor;
                    // A press landing on the arrival edge still stops the
                    // car, so the raw buttons are folded in here.
                    if (((signal | btn) & floor_bit(arrive_floor)) != '0) begin
                        state_next  = DOOR;
                        clear_mask  = floor_bit(arrive_floor);
                        timer_load  = 1'b1;
                        timer_value = DOOR_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            DOOR: begin
                // The current floor's bit was cleared on entry; any press
                // here only extends the door time and never re-latches.
                clear_mask = floor_bit(current);
                if ((btn & floor_bit(current)) != '0) begin
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (timer_zero) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Recover from a corrupted floor register.
        if (!floor_legal) begin
            state_next   = IDLE;
            current_next = FLOOR_MIN;
            clear_mask   = '0;
            timer_load   = 1'b0;
        end
    end

    // Clear has priority over a same-cycle press on the same bit.
    assign signal_next = (signal | btn) & ~clear_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            current <= FLOOR_MIN;
            signal  <= '0;
        end else begin
            state   <= state_next;
            current <= current_next;
            signal  <= signal_next;
        end
    end

    assign door_open = (state == DOOR);
    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);

endmodule
`default_nettype wire

// File: tb/tb_car_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_motion_ctrl
//  Description : Self-checking bench for car_motion_ctrl (FLOOR_TICKS=4,
//                DOOR_TICKS=3). Each scenario queues per-cycle stimulus and
//                the expected {current, signal, door_open, moving} after the
//                following edge, then replays and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_car_motion_ctrl;

    localparam int F = 4;
    localparam int D = 3;

    logic       clk;
    logic       rst;
    logic [7:0] btn;
    logic       up;
    logic       down;
    logic [3:0] current;
    logic [7:0] signal;
    logic       door_open;
    logic       moving;

    typedef struct packed {
        logic [7:0] b;
        logic       u;
        logic       d;
    } stim_t;

    stim_t       stim_q[$];
    logic [13:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    car_motion_ctrl #(
        .FLOOR_TICKS (F),
        .DOOR_TICKS  (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .up        (up),
        .down      (down),
        .current   (current),
        .signal    (signal),
        .door_open (door_open),
        .moving    (moving)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    task automatic push(input logic [7:0] b, input logic u, input logic d,
                        input logic [3:0] cur, input logic [7:0] sig,
                        input logic dr, input logic mv);
        stim_t s;
        s.b = b;
        s.u = u;
        s.d = d;
        stim_q.push_back(s);
        exp_q.push_back({cur, sig, dr, mv});
    endtask

    // One unobstructed floor hop: F cycles moving, then one IDLE cycle.
    task automatic push_hops(input logic [3:0] from, input int hops, input logic dir_up);
        logic [3:0] f;
        for (int h = 0; h < hops; h++) begin
            f = dir_up ? 4'(from + 4'(h)) : 4'(from - 4'(h));
            for (int c = 0; c < F; c++) push(8'h00, dir_up, !dir_up, f, 8'h00, 1'b0, 1'b1);
            push(8'h00, dir_up, !dir_up, dir_up ? 4'(f + 4'd1) : 4'(f - 4'd1), 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        stim_t       s;
        logic [13:0] e;
        int          n = 0;
        btn = 8'h00; up = 1'b0; down = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({current, signal, door_open, moving} !== {4'd1, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got cur=%0d sig=%h door=%b mov=%b, expected cur=1 sig=00 door=0 mov=0",
                     current, signal, door_open, moving);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) push(8'h00, 1'b0, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0);
        // down at the bottom floor must not move the car
        for (int i = 0; i < 5; i++) push(8'h00, 1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            btn = s.b; up = s.u; down = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n++;
            checks++;
            if ({current, signal, door_open, moving} !== e) begin
                errors++;
                $display("FAIL reset_idle step %0d: got cur=%0d sig=%h door=%b mov=%b, expected cur=%0d sig=%h door=%b mov=%b",
                         n, current, signal, door_open, moving, e[13:10], e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_move_up();
        stim_t       s;
        logic [13:0] e;
        int          n = 0;
        push(8'h04, 1'b1, 1'b0, 4'd1, 8'h04, 1'b0, 1'b1);
        for (int i = 0; i < F - 1; i++) push(8'h00, 1'b1, 1'b0, 4'd1, 8'h04, 1'b0, 1'b1);
        push(8'h00, 1'b1, 1'b0, 4'd2, 8'h04, 1'b0, 1'b0);
        for (int i = 0; i < F; i++) push(8'h00, 1'b1, 1'b0, 4'd2, 8'h04, 1'b0, 1'b1);
        push(8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < D - 1; i++) push(8'h00, 1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            btn = s.b; up = s.u; down = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n++;
            checks++;
            if ({current, signal, door_open, moving} !== e) begin
                errors++;
                $display("FAIL move_up step %0d: got cur=%0d sig=%h door=%b mov=%b, expected cur=%0d sig=%h door=%b mov=%b",
                         n, current, signal, door_open, moving, e[13:10], e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_boundaries();
        stim_t       s;
        logic [13:0] e;
        int          n = 0;
        push_hops(4'd3, 5, 1'b1);
        for (int i = 0; i < 10; i++) push(8'h00, 1'b1, 1'b0, 4'd8, 8'h00, 1'b0, 1'b0);
        push_hops(4'd8, 4, 1'b0);
        for (int i = 0; i < 10; i++) push(8'h00, 1'b1, 1'b1, 4'd4, 8'h00, 1'b0, 1'b0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            btn = s.b; up = s.u; down = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n++;
            checks++;
            if ({current, signal, door_open, moving} !== e) begin
                errors++;
                $display("FAIL boundaries step %0d: got cur=%0d sig=%h door=%b mov=%b, expected cur=%0d sig=%h door=%b mov=%b",
                         n, current, signal, door_open, moving, e[13:10], e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_door_reload();
        stim_t       s;
        logic [13:0] e;
        int          n = 0;
        push(8'h10, 1'b1, 1'b0, 4'd4, 8'h10, 1'b0, 1'b1);
        for (int i = 0; i < F - 1; i++) push(8'h00, 1'b0, 1'b0, 4'd4, 8'h10, 1'b0, 1'b1);
        push(8'h00, 1'b0, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0);
        // press at the open floor (reload) plus floor 1 (latch)
        push(8'h11, 1'b0, 1'b0, 4'd5, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < D - 1; i++) push(8'h00, 1'b0, 1'b0, 4'd5, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) push(8'h00, 1'b0, 1'b0, 4'd5, 8'h01, 1'b0, 1'b0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            btn = s.b; up = s.u; down = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n++;
            checks++;
            if ({current, signal, door_open, moving} !== e) begin
                errors++;
                $display("FAIL door_reload step %0d: got cur=%0d sig=%h door=%b mov=%b, expected cur=%0d sig=%h door=%b mov=%b",
                         n, current, signal, door_open, moving, e[13:10], e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset_mid_travel();
        stim_t       s;
        logic [13:0] e;
        int          n = 0;
        push(8'h80, 1'b1, 1'b0, 4'd5, 8'h81, 1'b0, 1'b1);
        for (int i = 0; i < F - 1; i++) push(8'h00, 1'b0, 1'b0, 4'd5, 8'h81, 1'b0, 1'b1);
        push(8'h00, 1'b0, 1'b0, 4'd6, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(8'h00, 1'b0, 1'b1, 4'd6, 8'h81, 1'b0, 1'b1);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            btn = s.b; up = s.u; down = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n++;
            checks++;
            if ({current, signal, door_open, moving} !== e) begin
                errors++;
                $display("FAIL mid_travel step %0d: got cur=%0d sig=%h door=%b mov=%b, expected cur=%0d sig=%h door=%b mov=%b",
                         n, current, signal, door_open, moving, e[13:10], e[9:2], e[1], e[0]);
            end
        end
        // asynchronous reset between edges
        #3;
        btn = 8'h00; up = 1'b0; down = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if ({current, signal, door_open, moving} !== {4'd1, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got cur=%0d sig=%h door=%b mov=%b, expected cur=1 sig=00 door=0 mov=0",
                     current, signal, door_open, moving);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h00, 1'b0, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            btn = s.b; up = s.u; down = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n++;
            checks++;
            if ({current, signal, door_open, moving} !== e) begin
                errors++;
                $display("FAIL after_reset step %0d: got cur=%0d sig=%h door=%b mov=%b, expected cur=%0d sig=%h door=%b mov=%b",
                         n, current, signal, door_open, moving, e[13:10], e[9:2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t       s;
        logic [13:0] e;
        int          n = 0;
        push_hops(4'd1, 2, 1'b1);
        for (int i = 0; i < F; i++) push(8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1);
        // press for floor 4 sampled on the arrival edge
        push(8'h08, 1'b0, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < D - 1; i++) push(8'h00, 1'b0, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0);
        // press at the current floor while IDLE: latch, then door
        push(8'h08, 1'b0, 1'b0, 4'd4, 8'h08, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < D - 1; i++) push(8'h00, 1'b0, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            btn = s.b; up = s.u; down = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n++;
            checks++;
            if ({current, signal, door_open, moving} !== e) begin
                errors++;
                $display("FAIL back_to_back step %0d: got cur=%0d sig=%h door=%b mov=%b, expected cur=%0d sig=%h door=%b mov=%b",
                         n, current, signal, door_open, moving, e[13:10], e[9:2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        btn  = 8'h00;
        up   = 1'b0;
        down = 1'b0;
        test_reset();
        test_move_up();
        test_boundaries();
        test_door_reload();
        test_reset_mid_travel();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
